// File: rtl/sram_mem_controller.sv
// MEM-stage data-memory controller for a 16-bit asynchronous SRAM.
// Each 32-bit access is two half-word cycles (low, then high) and a fixed settle wait.
module sram_mem_controller #(
    parameter int DATA_BASE   = 1024,
    parameter int WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_we_n,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic [31:0] BASE      = 32'(DATA_BASE);
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic        op_wr;
    logic [16:0] idx;
    logic [31:0] data;

    // Word index wraps modulo 2^17; addresses below DATA_BASE land at the top of SRAM.
    logic [31:0] offset;
    logic [16:0] req_idx;
    logic        unused_offset_bits;

    assign offset             = address - BASE;
    assign req_idx            = offset[18:2];
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

    assign sram_ce_n = 1'b0;
    assign sram_oe_n = 1'b0;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            op_wr     <= 1'b0;
            idx       <= '0;
            data      <= '0;
            read_data <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (wr_en || rd_en) begin
                        op_wr <= wr_en;
                        idx   <= req_idx;
                        data  <= write_data;
                    end
                end
                ST_LOW: begin
                    if (!op_wr) read_data[15:0] <= sram_dq_in;
                end
                ST_HIGH: begin
                    if (!op_wr) read_data[31:16] <= sram_dq_in;
                    cnt <= '0;
                end
                ST_WAIT: cnt <= cnt + 4'd1;
                default: ;
            endcase
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_next  = state;
        ready       = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (state)
            ST_IDLE: begin
                ready = ~(rd_en | wr_en);
                if (rd_en || wr_en) state_next = ST_LOW;
            end
            ST_LOW: begin
                sram_addr = {idx, 1'b0};
                if (op_wr) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = data[15:0];
                end
                state_next = ST_HIGH;
            end
            ST_HIGH: begin
                sram_addr = {idx, 1'b1};
                if (op_wr) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = data[31:16];
                end
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt == WAIT_LAST) state_next = ST_DONE;
            end
            ST_DONE: begin
                ready      = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench for sram_mem_controller with a small half-word SRAM model.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
module tb_sram_mem_controller;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_ub_n;
    logic        sram_lb_n;

    int checks;
    int failures;

    sram_mem_controller #(.DATA_BASE(1024), .WAIT_CYCLES(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n),
        .sram_ce_n   (sram_ce_n),
        .sram_oe_n   (sram_oe_n),
        .sram_ub_n   (sram_ub_n),
        .sram_lb_n   (sram_lb_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Only words 0..5 and 0x3FFFE/0x3FFFF are used, so 4 address bits cannot alias.
    logic [15:0] mem [16];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    end
    always @(posedge clk) begin
        if (!sram_we_n) mem[sram_addr[3:0]] <= sram_dq_out;
    end
    assign sram_dq_in = mem[sram_addr[3:0]];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          lat;
    logic [17:0] a1, a2;
    logic [15:0] q1, q2;
    logic        we1, we2, we3, oe1, oe3;
    logic [31:0] rd_done;

    // Drives a request from the current cycle (cycle 0) until ready, records
    // the SRAM-side signals of cycles 1..3, then drops the request.
    task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        wr_en = w;
        rd_en = r;
        address = a;
        write_data = d;
        lat = -1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (c == 1) begin a1 = sram_addr; q1 = sram_dq_out; we1 = sram_we_n; oe1 = sram_dq_oe; end
            if (c == 2) begin a2 = sram_addr; q2 = sram_dq_out; we2 = sram_we_n; end
            if (c == 3) begin we3 = sram_we_n; oe3 = sram_dq_oe; end
            if (ready) begin
                lat = c;
                rd_done = read_data;
                break;
            end
            tick();
        end
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    int t1, t2;
    logic [31:0] rd1;

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        rd_en = 1'b0;
        wr_en = 1'b0;
        address = '0;
        write_data = '0;

        // Reset with no request pending
        tick();
        tick();
        #1;
        check("rst_read_data", read_data, 32'h0);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_sram_addr", 32'(sram_addr), 32'd0);
        tick();
        rst = 1'b1;

        // Store 0xDEADBEEF at the base address
        access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
        check("st_latency", 32'(lat), 32'd6);
        check("st_lo_addr", 32'(a1), 32'd0);
        check("st_lo_dq", 32'(q1), 32'h0000BEEF);
        check("st_lo_we_n", 32'(we1), 32'd0);
        check("st_lo_oe", 32'(oe1), 32'd1);
        check("st_hi_addr", 32'(a2), 32'd1);
        check("st_hi_dq", 32'(q2), 32'h0000DEAD);
        check("st_hi_we_n", 32'(we2), 32'd0);
        check("st_wait_we_n", 32'(we3), 32'd1);
        check("st_wait_oe", 32'(oe3), 32'd0);
        check("st_mem0", 32'(mem[0]), 32'h0000BEEF);
        check("st_mem1", 32'(mem[1]), 32'h0000DEAD);
        check("st_read_data_kept", read_data, 32'h0);

        // Load it back; the result must hold after the request drops
        access(1'b0, 1'b1, 32'd1024, 32'h0);
        check("ld_latency", 32'(lat), 32'd6);
        check("ld_done_data", rd_done, 32'hDEADBEEF);
        check("ld_we_n", 32'(we1), 32'd1);
        repeat (3) tick();
        #1;
        check("ld_hold", read_data, 32'hDEADBEEF);
        check("idle_ready", 32'(ready), 32'd1);
        tick();

        // Mapping of base+8
        access(1'b1, 1'b0, 32'd1032, 32'hCAFEF00D);
        check("map1032_lo", 32'(a1), 32'd4);
        check("map1032_hi", 32'(a2), 32'd5);

        // Address below base wraps to the top of SRAM
        access(1'b1, 1'b0, 32'd1020, 32'h0BADC0DE);
        check("wrap_lo", 32'(a1), 32'h3FFFE);
        check("wrap_hi", 32'(a2), 32'h3FFFF);
        access(1'b0, 1'b1, 32'd1020, 32'h0);
        check("wrap_ld", rd_done, 32'h0BADC0DE);

        // Simultaneous read and write is a write; read_data untouched
        access(1'b1, 1'b1, 32'd1028, 32'h12345678);
        check("both_latency", 32'(lat), 32'd6);
        check("both_we_n", 32'(we1), 32'd0);
        check("both_mem2", 32'(mem[2]), 32'h00005678);
        check("both_mem3", 32'(mem[3]), 32'h00001234);
        check("both_read_data", read_data, 32'h0BADC0DE);

        // Reset during the WAIT phase of a write
        wr_en = 1'b1;
        address = 32'd1024;
        write_data = 32'h11112222;
        repeat (4) tick();
        #1;
        check("midrst_busy", 32'(ready), 32'd0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        wr_en = 1'b0;
        #1;
        check("midrst_we_n", 32'(sram_we_n), 32'd1);
        check("midrst_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("midrst_read_data", read_data, 32'h0);
        check("midrst_ready", 32'(ready), 32'd1);
        access(1'b0, 1'b1, 32'd1028, 32'h0);
        check("postrst_latency", 32'(lat), 32'd6);
        check("postrst_ld", rd_done, 32'h12345678);

        // Back-to-back loads with rd_en held throughout
        rd_en = 1'b1;
        address = 32'd1024;
        t1 = -1;
        t2 = -1;
        rd1 = '0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (ready) begin
                if (t1 < 0) begin
                    t1 = c;
                    rd1 = read_data;
                end else if (t2 < 0) begin
                    t2 = c;
                end
            end
            if (t2 >= 0) break;
            tick();
        end
        tick();
        rd_en = 1'b0;
        check("b2b_first", 32'(t1), 32'd6);
        check("b2b_spacing", 32'(t2 - t1), 32'd7);
        check("b2b_data", rd1, 32'h11112222);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- Sequences every MEM-stage data-memory access onto the board's 16-bit asynchronous SRAM.
- Splits each 32-bit load/store into two half-word SRAM cycles, then runs a fixed settle wait.
- Holds `ready` low for the whole access. The pipeline uses `~ready` to freeze all stages, and the forwarding unit only ever sees a stable MEM/WB stage.

Parameters:
- DATA_BASE, 1024, byte address mapped to SRAM word 0.
- WAIT_CYCLES, 3, settle cycles after the high half-word phase (legal range 1..15).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous reset, active-low; takes effect on a clk rising edge while 0.
- rd_en  input  1  load request from MEM stage, held until `ready`.
- wr_en  input  1  store request from MEM stage, held until `ready`.
- address  input  32  byte address from ALU result.
- write_data  input  32  store data (Val_Rm).
- read_data  output  32  registered load result.
- ready  output  1  access complete or no access pending; pipeline freeze = ~ready.
- sram_addr  output  18  SRAM half-word address.
- sram_dq_out  output  16  data driven to SRAM.
- sram_dq_in  input  16  data read from SRAM (async, valid same cycle as sram_addr).
- sram_dq_oe  output  1  1 = controller drives the DQ bus.
- sram_we_n  output  1  SRAM write strobe, active-low.
- sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n  output  1 each  tied 0.

Behaviour:
- Address mapping:
  - idx = (address - DATA_BASE)[18:2], 17 bits, modulo arithmetic with no range check.
  - Low half-word goes to sram_addr = {idx,1'b0}; high half-word to {idx,1'b1}.
- FSM states: IDLE, LOW, HIGH, WAIT, DONE.
- IDLE:
  - If wr_en|rd_en, latch op (write if wr_en, else read), idx and write_data; go to LOW.
  - wr_en and rd_en together are treated as a write; read_data is unchanged.
- LOW (1 cycle):
  - sram_addr = {idx,0}.
  - Write: sram_we_n = 0, sram_dq_oe = 1, sram_dq_out = data[15:0].
  - Read: capture sram_dq_in into read_data[15:0] at the end of the cycle.
  - Next state: HIGH.
- HIGH (1 cycle): same as LOW with {idx,1} and bits [31:16]; next state WAIT, wait counter cleared.
- WAIT:
  - sram_we_n = 1, sram_dq_oe = 0; counter increments.
  - After WAIT_CYCLES cycles in WAIT, go to DONE.
- DONE (1 cycle): ready = 1; go to IDLE.
- ready (combinational):
  - IDLE: ~(rd_en|wr_en).
  - LOW/HIGH/WAIT: 0.
  - DONE: 1.
- Latency: with the request first seen in IDLE at cycle 0, ready is 0 for cycles 0..(2+WAIT_CYCLES) and 1 in cycle 3+WAIT_CYCLES. Default: ready = 1 at cycle 6, 7 cycles total.
- read_data:
  - Valid in DONE and holds until the next read's LOW/HIGH captures.
  - Writes never modify it.
- Once latched, an access always completes, even if rd_en/wr_en drops or address changes mid-access.
- Back-to-back: DONE -> IDLE. If a new request is present in IDLE it starts then, so accesses are spaced 4+WAIT_CYCLES cycles apart.
- Idle outputs: sram_we_n = 1, sram_dq_oe = 0, sram_addr = 0, sram_dq_out = 0.
- Reset (rst = 0 at a clk edge), including mid-access:
  - state = IDLE, counter = 0, read_data = 0, latched op/idx/data = 0.
  - sram_we_n = 1, sram_dq_oe = 0.
  - Any in-flight write may be partially committed; this is not recovered.

Test Plan:
- Reset and idle: hold rst = 0 for 2 cycles with no request -> read_data = 0, sram_we_n = 1, sram_dq_oe = 0, ready = 1.
- Store timing and mapping:
  - Stimulus: wr_en, address = 1024, write_data = 32'hDEADBEEF at cycle 0.
  - Response: cycle 1 sram_addr = 0, dq_out = 16'hBEEF, we_n = 0; cycle 2 sram_addr = 1, dq_out = 16'hDEAD, we_n = 0.
  - ready = 0 in cycles 0..5 and 1 in cycle 6.
- Load: after the store, rd_en with address = 1024 (SRAM model) -> read_data = 32'hDEADBEEF in the DONE cycle (cycle 6); it holds after rd_en drops.
- Mapping/wrap:
  - address = 1032 -> sram_addr 4 then 5.
  - address = 1020 -> idx = 17'h1FFFF, sram_addr 18'h3FFFE then 18'h3FFFF.
- Simultaneous/priority: rd_en = wr_en = 1, address = 1028, data = 32'h12345678 -> SRAM words 2/3 written 5678/1234; read_data unchanged.
- Reset mid-access:
  - Stimulus: rst = 0 during WAIT of a write.
  - Response: next cycle state IDLE, we_n = 1, dq_oe = 0, read_data = 0.
  - Then, with rst = 1 and rd_en held, a new full 7-cycle access starts.
- Back-to-back: two loads held consecutively -> the second ready pulse occurs exactly 7 cycles after the first.
